// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Holds state codes, opcode/funct values, ALU control codes and mux selects.
// Pure constants; no logic lives here.
package mc_control_pkg;

  // FSM state encodings, exported on State for the debug display
  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct field (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// Bundle between the control FSM (master) and the multi-cycle datapath (slave).
// Step exists only when MC_CONTROL_STEP_EN is defined.
// Memory handshake is MemRead/MemWrite request held until MemReady.
interface mc_control_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
`ifdef MC_CONTROL_STEP_EN
  logic       Step;
`endif
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUCtrl;
  logic [1:0] PCSrc;
  logic [3:0] State;
  logic       IllegalOp;
  logic       MemErr;

  modport master (
`ifdef MC_CONTROL_STEP_EN
    input  Step,
`endif
    input  Op, Funct, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
    output RegWrite, ALUSrcA, ALUSrcB, ALUCtrl, PCSrc, State,
    output IllegalOp, MemErr
  );

  modport slave (
`ifdef MC_CONTROL_STEP_EN
    output Step,
`endif
    output Op, Funct, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
    input  RegWrite, ALUSrcA, ALUSrcB, ALUCtrl, PCSrc, State,
    input  IllegalOp, MemErr
  );
endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct to ALU control decoder with a valid flag for unknown functs.
// Latency: purely combinational.
// Backpressure: none.
module mc_alu_dec
  import mc_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       alu_vld
);

  // Map funct to ALU op; unknown functs fall back to add and flag invalid
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_vld  = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: alu_vld  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM; optional single-step gate via MC_CONTROL_STEP_EN.
// Latency: R/addi/sw 4 cycles, lw 5, beq/bne/j 3 with MemReady held high.
// Backpressure: memory states hold on MemReady=0 up to MEM_TIMEOUT cycles, then flag MemErr.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  mc_control_if.master bus
);

  // Counter value seen during the last allowed waiting cycle
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       mem_err_q, mem_err_d;

  logic [2:0] dec_ctrl;
  logic       dec_vld;
  logic       fetch_go;
  logic       mem_to;

  mc_alu_dec u_alu_dec (
    .funct    (bus.Funct),
    .alu_ctrl (dec_ctrl),
    .alu_vld  (dec_vld)
  );

  // Timeout fires only when the last allowed cycle also lacks MemReady
  assign mem_to = (cnt_q == TO_LAST) && !bus.MemReady;

`ifdef MC_CONTROL_STEP_EN
  logic step_q;
  logic armed_q, armed_d;
  logic fetch_done;

  assign fetch_go   = armed_q;
  assign fetch_done = (state_q == S_FETCH) && armed_q && bus.MemReady;

  // One Step rising edge arms exactly one fetch; a completed fetch disarms
  always_comb begin
    armed_d = armed_q;
    if (fetch_done) armed_d = 1'b0;
    if (bus.Step && !step_q) armed_d = 1'b1;
  end

  // Step edge detector and arm flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      step_q  <= bus.Step;
      armed_q <= armed_d;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  // Next state, timeout counter, sticky flags and all datapath controls
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    illegal_d    = illegal_q;
    mem_err_d    = mem_err_q;
    bus.PCEn     = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = SRCB_B;
    bus.ALUCtrl  = ALU_AND;
    bus.PCSrc    = PCSRC_ALU;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        bus.ALUSrcB = SRCB_FOUR;
        bus.ALUCtrl = ALU_ADD;
        if (fetch_go) begin
          bus.MemRead = 1'b1;
          if (bus.MemReady) begin
            bus.IRWrite = 1'b1;
            bus.PCEn    = 1'b1;
            state_d     = S_DECODE;
          end else if (mem_to) begin
            // Retry the fetch from the same PC with a fresh wait budget
            mem_err_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded
        bus.ALUSrcB = SRCB_SEXT_SH;
        bus.ALUCtrl = ALU_ADD;
        case (bus.Op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_SEXT;
        bus.ALUCtrl = ALU_ADD;
        state_d     = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.MemReady) begin
          state_d = S_MEMWB;
        end else if (mem_to) begin
          mem_err_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.MemReady) begin
          state_d = S_FETCH;
        end else if (mem_to) begin
          mem_err_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_B;
        if (dec_vld) begin
          bus.ALUCtrl = dec_ctrl;
          state_d     = S_ALUWB;
        end else begin
          // Unknown funct: abandon the instruction without a register write
          bus.ALUCtrl = ALU_ADD;
          illegal_d   = 1'b1;
          state_d     = S_FETCH;
        end
      end

      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_B;
        bus.ALUCtrl = ALU_SUB;
        bus.PCSrc   = PCSRC_ALUOUT;
        bus.PCEn    = (bus.Op == OP_BNE) ? !bus.Zero : bus.Zero;
        state_d     = S_FETCH;
      end

      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_SEXT;
        bus.ALUCtrl = ALU_ADD;
        state_d     = S_ADDIWB;
      end

      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        bus.PCSrc = PCSRC_JUMP;
        bus.PCEn  = 1'b1;
        state_d   = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // Any state change starts the next wait with a clean count
    if (state_d != state_q) cnt_d = '0;
  end

  // State, counter and sticky flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_RST;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign bus.State     = state_q;
  assign bus.IllegalOp = illegal_q;
  assign bus.MemErr    = mem_err_q;

endmodule
